// File: rtl/qspi_seq_engine.sv
// Flash command sequencer: walks CMD/ADDR/DUMMY/DATA phases of one QSPI frame,
// feeding the bit shifter one request at a time and framing chip select.
module qspi_seq_engine #(
  parameter int LEN_W       = 8,
  parameter int DUMMY_W     = 5,
  parameter int CS_HOLD_CYC = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [7:0]         cmd_i,
  input  logic [31:0]        addr_i,
  input  logic [2:0]         addr_bytes_i,
  input  logic [DUMMY_W-1:0] dummy_i,
  input  logic               dir_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [1:0]         cmd_lanes_i,
  input  logic [1:0]         addr_lanes_i,
  input  logic [1:0]         data_lanes_i,
  input  logic [31:0]        wdata_i,
  input  logic               wdata_valid_i,
  output logic               wdata_ready_o,
  output logic [31:0]        rdata_o,
  output logic [2:0]         rdata_bytes_o,
  output logic               rdata_valid_o,
  output logic               shf_valid_o,
  input  logic               shf_ready_i,
  output logic [1:0]         shf_mode_o,
  output logic [31:0]        shf_data_o,
  output logic [5:0]         shf_bits_o,
  output logic [1:0]         shf_lanes_o,
  input  logic [31:0]        shf_rdata_i,
  input  logic               shf_rvalid_i,
  output logic               cs_n_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int HOLD_W = $clog2(CS_HOLD_CYC + 1);
  localparam logic [1:0] MODE_TX = 2'b00, MODE_RX = 2'b01, MODE_DUMMY = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_HOLD, S_DONE
  } state_t;

  state_t state_q, state_d;
  state_t data_st, after_dummy, after_addr, after_cmd;

  logic [7:0]         cmd_q;
  logic [31:0]        addr_q;
  logic [2:0]         ab_q;
  logic [DUMMY_W-1:0] dummy_q;
  logic               dir_q;
  logic [LEN_W-1:0]   rem_q;
  logic [1:0]         cl_q, al_q, dl_q;
  logic               wait_q;
  logic [2:0]         cur_chunk_q;
  logic [HOLD_W-1:0]  hold_q;

  logic [2:0] chunk;
  logic       ab4, hs, xfer_done;

  function automatic logic [1:0] norm_lanes(input logic [1:0] l);
    return (l == 2'b11) ? 2'b00 : l;
  endfunction

  // Keeps the top n bytes of a left-aligned word; n=4 yields all ones.
  function automatic logic [31:0] byte_mask(input logic [2:0] n);
    logic [31:0] ones;
    ones = '1;
    return ~(ones >> {n, 3'b000});
  endfunction

  assign chunk     = (rem_q >= LEN_W'(4)) ? 3'd4 : rem_q[2:0];
  assign ab4       = (ab_q != 3'd3);
  assign hs        = shf_valid_o && shf_ready_i;
  // A transfer ends when the shifter goes idle again, or for RX when the data arrives.
  assign xfer_done = wait_q && ((state_q == S_RDATA) ? shf_rvalid_i : shf_ready_i);

  always_comb begin
    data_st     = dir_q ? S_RDATA : S_WDATA;
    after_dummy = (rem_q != '0) ? data_st : S_HOLD;
    after_addr  = (dummy_q != '0) ? S_DUMMY : after_dummy;
    after_cmd   = (ab_q != 3'd0) ? S_ADDR : after_addr;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:           if (start_i) state_d = S_CMD;
      S_CMD:            if (xfer_done) state_d = after_cmd;
      S_ADDR:           if (xfer_done) state_d = after_addr;
      S_DUMMY:          if (xfer_done) state_d = after_dummy;
      S_WDATA, S_RDATA: if (xfer_done && rem_q == '0) state_d = S_HOLD;
      S_HOLD:           if (hold_q == HOLD_W'(CS_HOLD_CYC - 1)) state_d = S_DONE;
      S_DONE:           state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shf_valid_o   = 1'b0;
    shf_mode_o    = MODE_TX;
    shf_data_o    = '0;
    shf_bits_o    = '0;
    shf_lanes_o   = '0;
    wdata_ready_o = 1'b0;
    case (state_q)
      S_CMD: begin
        shf_valid_o = !wait_q;
        shf_data_o  = {cmd_q, 24'h0};
        shf_bits_o  = 6'd8;
        shf_lanes_o = norm_lanes(cl_q);
      end
      S_ADDR: begin
        shf_valid_o = !wait_q;
        shf_data_o  = ab4 ? addr_q : {addr_q[23:0], 8'h0};
        shf_bits_o  = ab4 ? 6'd32 : 6'd24;
        shf_lanes_o = norm_lanes(al_q);
      end
      S_DUMMY: begin
        shf_valid_o = !wait_q;
        shf_mode_o  = MODE_DUMMY;
        shf_bits_o  = 6'(dummy_q);
        shf_lanes_o = norm_lanes(dl_q);
      end
      S_WDATA: begin
        shf_valid_o   = !wait_q && wdata_valid_i;
        shf_data_o    = wdata_i & byte_mask(chunk);
        shf_bits_o    = {chunk, 3'b000};
        shf_lanes_o   = norm_lanes(dl_q);
        wdata_ready_o = !wait_q && wdata_valid_i && shf_ready_i;
      end
      S_RDATA: begin
        shf_valid_o = !wait_q;
        shf_mode_o  = MODE_RX;
        shf_bits_o  = {chunk, 3'b000};
        shf_lanes_o = norm_lanes(dl_q);
      end
      default: ;
    endcase
    cs_n_o = (state_q == S_IDLE) || (state_q == S_DONE);
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmd_q         <= '0;
      addr_q        <= '0;
      ab_q          <= '0;
      dummy_q       <= '0;
      dir_q         <= 1'b0;
      rem_q         <= '0;
      cl_q          <= '0;
      al_q          <= '0;
      dl_q          <= '0;
      wait_q        <= 1'b0;
      cur_chunk_q   <= '0;
      hold_q        <= '0;
      rdata_o       <= '0;
      rdata_bytes_o <= '0;
      rdata_valid_o <= 1'b0;
    end else begin
      rdata_valid_o <= 1'b0;
      if (state_q == S_IDLE && start_i) begin
        cmd_q   <= cmd_i;
        addr_q  <= addr_i;
        ab_q    <= addr_bytes_i;
        dummy_q <= dummy_i;
        dir_q   <= dir_i;
        rem_q   <= len_i;
        cl_q    <= cmd_lanes_i;
        al_q    <= addr_lanes_i;
        dl_q    <= data_lanes_i;
        wait_q  <= 1'b0;
      end
      if (hs) begin
        wait_q      <= 1'b1;
        cur_chunk_q <= chunk;
        if (state_q == S_WDATA || state_q == S_RDATA) rem_q <= rem_q - LEN_W'(chunk);
      end else if (xfer_done) begin
        wait_q <= 1'b0;
      end
      if (state_q == S_RDATA && xfer_done) begin
        rdata_valid_o <= 1'b1;
        rdata_o       <= shf_rdata_i & byte_mask(cur_chunk_q);
        rdata_bytes_o <= cur_chunk_q;
      end
      hold_q <= (state_q == S_HOLD) ? hold_q + HOLD_W'(1) : '0;
    end
  end

endmodule
